// File: rtl/rr_stream_pkg.sv
// rr_stream_pkg: shared defaults and sizing helper for the stream packer
// Holds the default byte width, bytes per word, output FIFO depth and the
// width of the per-word byte count (must represent 0..PACK_N).
package rr_stream_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_PACK_N = 4;
  localparam int DEF_OFIFO_DEPTH = 4;
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction
  localparam int DEF_CNT_W = cnt_w(DEF_PACK_N);
endpackage

// File: rtl/word_fifo.sv
// word_fifo: synchronous first-word-fall-through FIFO with async active-low reset
// Ports: clk, rst_n; push/wdata write the tail; pop drops the head;
// rdata shows the head entry (0 when empty); full/empty status.
// A push while full is accepted only when a pop frees a slot on the same edge.
module word_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wptr, rptr;
  logic [W-1:0] mem [DEPTH];
  logic do_push, do_pop;
  assign empty = wptr == rptr;
  // one extra pointer bit tells a full ring from an empty one
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata = empty ? '0 : mem[rptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop) rptr <= rptr + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/rr_stream_packer.sv
// rr_stream_packer: packs PACK_N bytes per word into a valid/ready output FIFO
// Ports: clk, rst_n (async, active low); din_valid/din byte stream (never
// stalls); flush emits a partial word; out_valid/out_ready/out_data/out_count
// present the FIFO head; overflow is sticky on a dropped word, cleared by clr_ovf.
module rr_stream_packer
  import rr_stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PACK_N = DEF_PACK_N,
  parameter int OFIFO_DEPTH = DEF_OFIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     din_valid,
  input  logic [DATA_W-1:0]        din,
  input  logic                     flush,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W*PACK_N-1:0] out_data,
  output logic [$clog2(PACK_N):0]  out_count,
  output logic                     overflow,
  input  logic                     clr_ovf
);
  localparam int CW = cnt_w(PACK_N);
  localparam int WW = DATA_W * PACK_N;
  logic [CW-1:0] cnt, ncnt;
  logic [PACK_N-1:0][DATA_W-1:0] lanes, merged;
  logic push, pop, full, empty;
  logic [CW+WW-1:0] head;
  // this cycle's byte is merged in before deciding to push, so a flush on the
  // completing byte yields exactly one full word
  always_comb begin
    merged = lanes;
    for (int i = 0; i < PACK_N; i++)
      if (din_valid && cnt == CW'(i)) merged[i] = din;
  end
  assign ncnt = cnt + CW'(din_valid);
  assign push = (ncnt == CW'(PACK_N)) | (flush & (ncnt != '0));
  assign pop = ~empty & out_ready;
  assign out_valid = ~empty;
  assign {out_count, out_data} = head;
  word_fifo #(.W(CW + WW), .DEPTH(OFIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .wdata({ncnt, merged}),
    .rdata(head),
    .full (full),
    .empty(empty)
  );
  // lanes clear on every push, so a partial word carries zeros in unused lanes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      lanes <= '0;
      overflow <= 1'b0;
    end else begin
      cnt <= push ? '0 : ncnt;
      lanes <= push ? '0 : merged;
      overflow <= (push & full & ~pop) | (overflow & ~clr_ovf);
    end
endmodule

// File: tb/tb_rr_stream_packer.sv
// tb_rr_stream_packer: directed vector bench for rr_stream_packer
module tb_rr_stream_packer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic din_valid = 1'b0, flush = 1'b0, out_ready = 1'b0, clr_ovf = 1'b0;
  logic [7:0] din = '0;
  logic out_valid, overflow;
  logic [31:0] out_data;
  logic [2:0] out_count;
  int total = 0, bad = 0;

  typedef struct {
    logic dv;
    logic [7:0] d;
    logic fl;
    logic rdy;
    logic clr;
    logic ev;
    logic [31:0] ed;
    logic [2:0] ec;
    logic eo;
  } vec_t;
  vec_t tv[$];

  always #5 clk = ~clk;

  rr_stream_packer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_valid(din_valid),
    .din      (din),
    .flush    (flush),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_count(out_count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [31:0] ed,
                         input logic [2:0] ec, input logic eo);
    chk({tag, ".valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".data"}, out_data, ed);
    chk({tag, ".count"}, 32'(out_count), 32'(ec));
    chk({tag, ".ovf"}, 32'(overflow), 32'(eo));
  endtask

  task automatic step(input logic dv, input logic [7:0] d, input logic fl,
                      input logic rdy, input logic clr);
    din_valid = dv; din = d; flush = fl; out_ready = rdy; clr_ovf = clr;
    @(posedge clk);
    #1;
    din_valid = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic addv(input logic dv, input logic [7:0] d, input logic fl, input logic rdy,
                      input logic ev, input logic [31:0] ed, input logic [2:0] ec);
    vec_t v;
    v.dv = dv; v.d = d; v.fl = fl; v.rdy = rdy; v.clr = 1'b0;
    v.ev = ev; v.ed = ed; v.ec = ec; v.eo = 1'b0;
    tv.push_back(v);
  endtask

  function automatic logic [7:0] mkb(input int base, input int k, input int j);
    return 8'(base + 16 * j + k);
  endfunction

  function automatic logic [31:0] mkw(input int base, input int k);
    return {mkb(base, k, 3), mkb(base, k, 2), mkb(base, k, 1), mkb(base, k, 0)};
  endfunction

  task automatic push_word(input int base, input int k, input logic rdy);
    for (int j = 0; j < 4; j++) step(1'b1, mkb(base, k, j), 1'b0, rdy, 1'b0);
  endtask

  initial begin
    // 1: four consecutive bytes, popped the cycle after it appears
    addv(1, 8'h87, 0, 1, 0, 0, 0);
    addv(1, 8'h56, 0, 1, 0, 0, 0);
    addv(1, 8'h09, 0, 1, 0, 0, 0);
    addv(1, 8'h13, 0, 1, 1, 32'h13095687, 4);
    addv(0, 8'h00, 0, 1, 0, 0, 0);
    // 2: bubbles between bytes, din ignored while invalid
    addv(1, 8'h87, 0, 1, 0, 0, 0);
    addv(0, 8'hFF, 0, 1, 0, 0, 0);
    addv(1, 8'h56, 0, 1, 0, 0, 0);
    addv(0, 8'hFF, 0, 1, 0, 0, 0);
    addv(1, 8'h09, 0, 1, 0, 0, 0);
    addv(0, 8'hFF, 0, 1, 0, 0, 0);
    addv(1, 8'h13, 0, 1, 1, 32'h13095687, 4);
    addv(0, 8'h00, 0, 1, 0, 0, 0);
    addv(0, 8'h00, 0, 1, 0, 0, 0);
    // 3: partial flush, then an empty flush does nothing
    addv(1, 8'h0A, 0, 1, 0, 0, 0);
    addv(1, 8'h14, 0, 1, 0, 0, 0);
    addv(1, 8'h1E, 0, 1, 0, 0, 0);
    addv(0, 8'h00, 1, 1, 1, 32'h001E140A, 3);
    addv(0, 8'h00, 0, 1, 0, 0, 0);
    addv(0, 8'h00, 1, 1, 0, 0, 0);
    addv(0, 8'h00, 0, 1, 0, 0, 0);
    // flush on the completing byte gives one full word
    addv(1, 8'h01, 0, 1, 0, 0, 0);
    addv(1, 8'h02, 0, 1, 0, 0, 0);
    addv(1, 8'h03, 0, 1, 0, 0, 0);
    addv(1, 8'h04, 1, 1, 1, 32'h04030201, 4);
    addv(0, 8'h00, 0, 1, 0, 0, 0);
    // flush in the same cycle as a byte includes that byte
    addv(1, 8'h05, 0, 1, 0, 0, 0);
    addv(1, 8'h06, 1, 1, 1, 32'h00000605, 2);
    addv(0, 8'h00, 0, 1, 0, 0, 0);
    // a single byte flushed alone
    addv(1, 8'hAB, 1, 1, 1, 32'h000000AB, 1);
    addv(0, 8'h00, 0, 1, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].dv, tv[i].d, tv[i].fl, tv[i].rdy, tv[i].clr);
      chk_out($sformatf("vec%0d", i), tv[i].ev, tv[i].ed, tv[i].ec, tv[i].eo);
    end

    // 4: fill with out_ready low, fifth word dropped, sticky overflow
    for (int k = 0; k < 5; k++) begin
      push_word(16, k, 1'b0);
      chk_out($sformatf("fill%0d", k), 1, mkw(16, 0), 4, k == 4);
    end
    repeat (2) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("ovf_hold", 32'(overflow), 1);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow), 0);
    for (int k = 0; k < 4; k++) begin
      chk_out($sformatf("drain%0d", k), 1, mkw(16, k), 4, 0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    chk_out("drained", 0, 0, 0, 0);

    // 5: push into a full FIFO on the same edge as a pop, across pointer wrap
    for (int k = 0; k < 4; k++) push_word(80, k, 1'b0);
    chk_out("full5", 1, mkw(80, 0), 4, 0);
    for (int j = 0; j < 3; j++) step(1'b1, mkb(80, 4, j), 1'b0, 1'b0, 1'b0);
    step(1'b1, mkb(80, 4, 3), 1'b0, 1'b1, 1'b0);
    chk_out("pushpop", 1, mkw(80, 1), 4, 0);
    for (int k = 1; k < 5; k++) begin
      chk_out($sformatf("wrap%0d", k), 1, mkw(80, k), 4, 0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    chk_out("wrap_empty", 0, 0, 0, 0);

    // 6: asynchronous reset with buffered words, a partial word and overflow set
    for (int k = 0; k < 5; k++) push_word(16, k, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hDD, 1'b0, 1'b0, 1'b0);
    chk_out("pre_rst", 1, mkw(16, 0), 4, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hC4, 1'b0, 1'b0, 1'b0);
    chk_out("post_rst", 1, 32'hC4C3C2C1, 4, 0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk_out("post_rst_pop", 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
